// File: rtl/dphy_hs_pkg.sv
// Shared definitions for the D-PHY data-lane HS path.
//   ser_state_t    : serializer FSM states, Gray-adjacent encoding
//   DPHY_SYNC_BYTE : HS sync byte sent ahead of the payload
//   DPHY_DATA_W    : default parallel byte width
package dphy_hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        TRAIL = 2'b11
    } ser_state_t;

    localparam logic [7:0]  DPHY_SYNC_BYTE = 8'hB8;
    localparam int unsigned DPHY_DATA_W    = 8;

endpackage

// File: rtl/data_hs_serializer_if.sv
// Handshake bundle between the HS controller (master) and the serializer (slave).
//   ser_en, ser_valid, prll_data, trail, trail_sel : controller -> serializer
//   hs_out, hs_oe, ser_end, byte_ack               : serializer -> controller / lane
//   tx_byte_cnt                                    : present only with DPHY_SER_BYTECNT_EN
interface data_hs_serializer_if
    import dphy_hs_pkg::*;
#(
    parameter int unsigned DATA_W = DPHY_DATA_W
);
    logic              ser_en;
    logic              ser_valid;
    logic [DATA_W-1:0] prll_data;
    logic              trail;
    logic              trail_sel;
    logic              hs_out;
    logic              hs_oe;
    logic              ser_end;
    logic              byte_ack;
`ifdef DPHY_SER_BYTECNT_EN
    logic [15:0]       tx_byte_cnt;

    modport master (
        output ser_en, ser_valid, prll_data, trail, trail_sel,
        input  hs_out, hs_oe, ser_end, byte_ack, tx_byte_cnt
    );
    modport slave (
        input  ser_en, ser_valid, prll_data, trail, trail_sel,
        output hs_out, hs_oe, ser_end, byte_ack, tx_byte_cnt
    );
`else
    modport master (
        output ser_en, ser_valid, prll_data, trail, trail_sel,
        input  hs_out, hs_oe, ser_end, byte_ack
    );
    modport slave (
        input  ser_en, ser_valid, prll_data, trail, trail_sel,
        output hs_out, hs_oe, ser_end, byte_ack
    );
`endif
endinterface

// File: rtl/dphy_shift_reg.sv
// Loadable right-shift register; bit 0 is the serial output.
//   clk, rst : clock, asynchronous active-high reset (clears to zero)
//   load     : capture din (has priority over shift)
//   shift    : shift right by one, zero fill at the MSB
//   din      : parallel load value
//   dout     : current bit 0
module dphy_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[W-1:1]};
        end
    end

    assign dout = q[0];
endmodule

// File: rtl/data_hs_serializer.sv
// HS data-lane serializer: shifts the controller's byte stream out LSB-first,
// one bit per clk, then holds the trail level until ser_en drops.
//   clk, rst : bit-rate clock, asynchronous active-high reset
//   hs       : data_hs_serializer_if slave (ser_en, ser_valid, prll_data, trail,
//              trail_sel in; hs_out, hs_oe, ser_end, byte_ack out)
// Optional: define DPHY_SER_BYTECNT_EN to add hs.tx_byte_cnt, a per-burst count
// of captured bytes.
module data_hs_serializer
    import dphy_hs_pkg::*;
#(
    parameter int unsigned DATA_W   = DPHY_DATA_W,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    data_hs_serializer_if.slave  hs
);
    localparam int unsigned     CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DATA_W - 2);

    ser_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             trail_q;
    logic             hs_oe_q;
    logic             ser_end_q;
    logic             byte_ack_q;
    logic             shreg_bit0;
    logic             hs_out_c;

    logic at_boundary;
    logic load;
    logic shift;

    assign at_boundary = (state == SHIFT) && (bit_cnt == CNT_LAST);
    assign load  = hs.ser_en && hs.ser_valid && ((state == IDLE) || at_boundary);
    assign shift = (state == SHIFT) && hs.ser_en && !at_boundary;

    dphy_shift_reg #(
        .W (DATA_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (hs.prll_data),
        .dout  (shreg_bit0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            trail_q    <= 1'b0;
            hs_oe_q    <= 1'b0;
            ser_end_q  <= 1'b1;
            byte_ack_q <= 1'b0;
        end else begin
            byte_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    hs_oe_q   <= 1'b0;
                    ser_end_q <= 1'b1;
                    if (load) begin
                        state      <= SHIFT;
                        bit_cnt    <= '0;
                        byte_ack_q <= 1'b1;
                        hs_oe_q    <= 1'b1;
                        ser_end_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // ser_en low wins over everything, including a boundary capture
                    if (!hs.ser_en) begin
                        state     <= IDLE;
                        hs_oe_q   <= 1'b0;
                        ser_end_q <= 1'b1;
                    end else if (!at_boundary) begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        // ser_end is registered, so raise it one bit early
                        ser_end_q <= (bit_cnt == CNT_PRE);
                    end else if (hs.ser_valid) begin
                        bit_cnt    <= '0;
                        byte_ack_q <= 1'b1;
                        ser_end_q  <= 1'b0;
                    end else begin
                        state     <= TRAIL;
                        trail_q   <= hs.trail;
                        ser_end_q <= 1'b1;
                    end
                end
                TRAIL: begin
                    if (!hs.ser_en) begin
                        state   <= IDLE;
                        hs_oe_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    hs_oe_q   <= 1'b0;
                    ser_end_q <= 1'b1;
                end
            endcase
        end
    end

    // hs_out is a select between registered sources; only the idle trail_sel
    // override passes the trail input straight through.
    always_comb begin
        hs_out_c = IDLE_LVL;
        case (state)
            SHIFT:   hs_out_c = shreg_bit0;
            TRAIL:   hs_out_c = trail_q;
            default: hs_out_c = hs.trail_sel ? hs.trail : IDLE_LVL;
        endcase
    end

    assign hs.hs_out   = hs_out_c;
    assign hs.hs_oe    = hs_oe_q;
    assign hs.ser_end  = ser_end_q;
    assign hs.byte_ack = byte_ack_q;

`ifdef DPHY_SER_BYTECNT_EN
    logic [15:0] byte_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
        end else if ((state == IDLE) && load) begin
            byte_cnt_q <= '0;
        end else if (byte_ack_q) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
        end
    end

    assign hs.tx_byte_cnt = byte_cnt_q;
`endif
endmodule
